seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1024, clocks per digit slot; legal range 2..65535.
REQ-002 Parameter BLANK_CYC, default 64, blanked clocks at the start of each slot; legal range 0..SCAN_DIV-1.
REQ-003 Parameter BLINK_FRAMES, default 128, frames per blink half-period; minimum 1.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Ports in0, in1, in2, in3, input, 4 bits each: candidate digit values for digits 0..3.
REQ-007 Port upd_req, input, 1 bit: level request to load in0..in3 into the shadow registers.
REQ-008 Port upd_ack, output, 1 bit: one-cycle pulse marking the cycle the shadow load occurs.
REQ-009 Port duty, input, 3 bits: brightness, 0 dimmest to 7 full.
REQ-010 Port blink_mask, input, 4 bits: bit k set means digit k blinks.
REQ-011 Port seg7_selected, output, 4 bits: active-low digit select; digit k lit is the value with only bit k low.
REQ-012 Port seg7outvalue, output, 4 bits: value of the selected digit.
REQ-013 Port frame_start, output, 1 bit: high during cycle 0 of slot 0.

Function
REQ-014 slot_cnt counts 0..SCAN_DIV-1 and wraps to 0; on wrap, slot advances 0,1,2,3,0 in that order.
REQ-015 Frame boundary is the cycle with slot==3 and slot_cnt==SCAN_DIV-1; at that edge frame_cnt (3 bits, wrapping) increments.
REQ-016 Digit k is lit when all hold: slot==k; slot_cnt>=BLANK_CYC; frame_cnt<=duty; blink not suppressing it (REQ-021).
REQ-017 While lit, seg7_selected has only bit k low and seg7outvalue equals shadow k.
REQ-018 While not lit, seg7_selected==4'b1111 and seg7outvalue==4'd0.
REQ-019 seg7_selected and seg7outvalue are combinational decodes of registered state only, with no path from any input port.
REQ-020 Update handshake: if upd_req is high on the frame-boundary cycle, shadow0..3 load in0..in3 at that edge, and upd_ack is high that same cycle only.
REQ-020a At all other times upd_ack is 0 and the shadows hold; a request held across several frames loads once per frame.
REQ-020b The first frame using the new shadows is the one starting after the load edge.
REQ-021 Blink: blink_phase toggles every BLINK_FRAMES frame boundaries; when blink_phase==1, digits with blink_mask bit set are unlit.
REQ-022 duty and blink_mask are sampled live each cycle; a change mid-slot takes effect on the next cycle.
REQ-023 duty==7 means lit in every frame; duty==0 means lit in 1 of 8 frames.

Reset
REQ-024 While rst is high at a clk edge, the following clear to 0: slot, slot_cnt, frame_cnt, blink_phase, blink frame counter, shadow0..3.
REQ-025 Outputs after reset: seg7_selected==4'b1111 (BLANK_CYC>0) and seg7outvalue==0, upd_ack==0, frame_start==1.
REQ-026 Reset asserted mid-slot or mid-handshake aborts the slot immediately; no upd_ack is issued for that cycle.

Configuration
REQ-027 Macro SEG7_BLINK_EN defined: the blink counter, blink_phase and REQ-021 are implemented.
REQ-028 Macro SEG7_BLINK_EN undefined: blink logic is not built; blink_mask is ignored and blink_phase is treated as 0; the port remains present.

Verification
REQ-029 SCAN_DIV=8, BLANK_CYC=2, duty=7, no updates: after reset, seg7_selected repeats 1111,1111,then 1110 x6, then 1111 x2, then 1101 x6, and so on; period 32 clocks.
REQ-030 in0..3=1,2,3,4 and upd_req held high: at the first frame boundary upd_ack pulses once; the next frame shows seg7outvalue 1,2,3,4 in digits 0..3.
REQ-031 duty=1 for 8 frames: digits are lit only in frames with frame_cnt 0 and 1, and fully blank in the other 6.
REQ-032 SEG7_BLINK_EN defined, BLINK_FRAMES=2, blink_mask=4'b0100: digit 2 is lit 2 frames, blank 2 frames, repeating; other digits are unaffected.
REQ-033 rst asserted for one cycle at slot 2, slot_cnt 5: the next cycle has slot 0, slot_cnt 0, outputs 1111/0, and shadows 0.
REQ-034 SEG7_BLINK_EN undefined, blink_mask=4'b1111: display is identical to the blink_mask=0 case over 16 frames.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with per-slot blanking,
// frame-based PWM brightness, frame-synchronous shadow update and optional blink.
// Optional feature macro: SEG7_BLINK_EN (blink counter, blink_phase, blink_mask honoured).
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 1024,
    parameter int unsigned BLANK_CYC    = 64,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic       upd_req,
    output logic       upd_ack,
    input  logic [2:0] duty,
    input  logic [3:0] blink_mask,
    output logic [3:0] seg7_selected,
    output logic [3:0] seg7outvalue,
    output logic       frame_start
);

    localparam int unsigned      CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [2:0]       frame_cnt_q, frame_cnt_d;
    logic [3:0][3:0]  shadow_q;
    logic [2:0]       duty_q;
    logic             frame_end;
    logic             blink_off;
    logic             lit;

    // Last cycle of slot 3: the only edge where frames roll over and shadows may load
    assign frame_end = (slot_q == 2'd3) && (slot_cnt_q == CNT_LAST);
    assign upd_ack   = frame_end && upd_req && !rst;

    // Next-state for the scan position counters
    always_comb begin
        slot_cnt_d  = slot_cnt_q + CNT_W'(1);
        slot_d      = slot_q;
        frame_cnt_d = frame_cnt_q;
        if (slot_cnt_q == CNT_LAST) begin
            slot_cnt_d = '0;
            slot_d     = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
                frame_cnt_d = frame_cnt_q + 3'd1;
            end
        end
    end

    // Scan position, shadow registers and live-sampled brightness
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q  <= '0;
            slot_q      <= '0;
            frame_cnt_q <= '0;
            shadow_q    <= '0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            slot_q      <= slot_d;
            frame_cnt_q <= frame_cnt_d;
            if (upd_ack) begin
                shadow_q <= {in3, in2, in1, in0};
            end
        end
        duty_q <= duty;
    end

`ifdef SEG7_BLINK_EN
    localparam int unsigned      BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [3:0]       blink_mask_q;

    // Blink phase flips after every BLINK_FRAMES frame boundaries
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    // Blink state registers; mask is sampled live like duty
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
        blink_mask_q <= blink_mask;
    end

    assign blink_off = blink_phase_q & blink_mask_q[slot_q];
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign blink_off         = 1'b0;
`endif

    // Display decode uses registered state only, so no input reaches the pins
    assign lit           = (slot_cnt_q >= BLANK_END) && (frame_cnt_q <= duty_q) && !blink_off;
    assign seg7_selected = lit ? ~(4'b0001 << slot_q) : 4'b1111;
    assign seg7outvalue  = lit ? shadow_q[slot_q] : 4'd0;
    assign frame_start   = (slot_q == 2'd0) && (slot_cnt_q == '0);

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: frame-arithmetic reference model plus
// directed literal checks and randomized traffic. Honours SEG7_BLINK_EN.
module tb_seg7_scan_ctrl;

    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in0, in1, in2, in3;
    logic       upd_req;
    logic       upd_ack;
    logic [2:0] duty;
    logic [3:0] blink_mask;
    logic [3:0] seg7_selected;
    logic [3:0] seg7outvalue;
    logic       frame_start;

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BL), .BLINK_FRAMES(BF)) dut (
        .clk           (clk),
        .rst           (rst),
        .in0           (in0),
        .in1           (in1),
        .in2           (in2),
        .in3           (in3),
        .upd_req       (upd_req),
        .upd_ack       (upd_ack),
        .duty          (duty),
        .blink_mask    (blink_mask),
        .seg7_selected (seg7_selected),
        .seg7outvalue  (seg7outvalue),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: everything derived from cycle count since reset
    int         m_n;
    logic [3:0] m_sh [4];
    logic [2:0] m_duty;
    logic [3:0] m_mask;
    bit         m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_n = 0;
            for (int k = 0; k < 4; k++) m_sh[k] = 4'd0;
            m_valid = 1;
        end else if (m_valid) begin
            if ((m_n % FRAME) == FRAME - 1 && upd_req) begin
                m_sh[0] = in0; m_sh[1] = in1; m_sh[2] = in2; m_sh[3] = in3;
            end
            m_n++;
        end
        m_duty = duty;
        m_mask = blink_mask;
    end

    int         e_cnt, e_slot, e_frame, e_phase;
    logic       e_lit;
    logic [3:0] e_sel, e_val;

    always @(negedge clk) begin
        if (m_valid) begin
            e_cnt   = m_n % SD;
            e_slot  = (m_n / SD) % 4;
            e_frame = m_n / FRAME;
`ifdef SEG7_BLINK_EN
            e_phase = (e_frame / BF) % 2;
`else
            e_phase = 0;
`endif
            e_lit = (e_cnt >= BL) && ((e_frame % 8) <= int'(m_duty))
                    && !(e_phase == 1 && m_mask[e_slot]);
            e_sel = e_lit ? ~(4'b0001 << e_slot) : 4'b1111;
            e_val = e_lit ? m_sh[e_slot] : 4'd0;
            chk("model_sel", 32'(seg7_selected), 32'(e_sel));
            chk("model_val", 32'(seg7outvalue), 32'(e_val));
            chk("model_fs",  32'(frame_start), 32'((m_n % FRAME) == 0));
            chk("model_ack", 32'(upd_ack),
                32'(((m_n % FRAME) == FRAME - 1) && upd_req && !rst));
        end
    end

    // ---------------- stimulus and literal pins
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp29 [16];
    int         lit_cnt, d2_cnt, d0_cnt;
    bit         seen;

    initial begin
        rst = 1'b1; upd_req = 1'b0; duty = 3'd7; blink_mask = 4'd0;
        in0 = 4'hA; in1 = 4'hB; in2 = 4'hC; in3 = 4'hD;
        for (int i = 0; i < 16; i++)
            exp29[i] = (i % 8 < 2) ? 4'b1111 : ((i < 8) ? 4'b1110 : 4'b1101);
        step(); step();
        rst = 1'b0;

        // Reset outputs and the first half-frame selection sequence
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("rst_val", 32'(seg7outvalue), 32'd0);
                chk("rst_ack", 32'(upd_ack), 32'd0);
                chk("rst_fs",  32'(frame_start), 32'd1);
            end
            chk("scan_seq", 32'(seg7_selected), 32'(exp29[i]));
            step();
        end

        // Held update request loads at the frame boundary
        in0 = 4'd1; in1 = 4'd2; in2 = 4'd3; in3 = 4'd4; upd_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (upd_ack) seen = 1;
            else step();
        end
        chk("ack_seen", 32'(seen), 32'd1);
        step();
        upd_req = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 0) chk("new_frame_fs", 32'(frame_start), 32'd1);
            if (i % SD == 2) chk("new_value", 32'(seg7outvalue), 32'(i / SD + 1));
            step();
        end

        // duty=1 over eight frames: two lit frames of 4x6 cycles each
        duty = 3'd1;
        lit_cnt = 0;
        for (int i = 0; i < 8 * FRAME; i++) begin
            @(negedge clk);
            if (seg7_selected != 4'b1111) lit_cnt++;
            step();
        end
        chk("duty1_lit", 32'(lit_cnt), 32'd48);

        // Reset mid-slot at slot 2, count 5
        for (int i = 0; i < 21; i++) step();
        rst = 1'b1; upd_req = 1'b1;
        step();
        rst = 1'b0; upd_req = 1'b0;
        @(negedge clk);
        chk("midrst_sel", 32'(seg7_selected), 32'hF);
        chk("midrst_val", 32'(seg7outvalue), 32'd0);
        chk("midrst_fs",  32'(frame_start), 32'd1);
        step(); step();
        @(negedge clk);
        chk("midrst_sel2", 32'(seg7_selected), 32'hE);
        chk("midrst_shadow", 32'(seg7outvalue), 32'd0);

        // Reset on the boundary cycle suppresses the acknowledge
        for (int i = 0; i < FRAME - 3; i++) step();
        rst = 1'b1; upd_req = 1'b1;
        @(negedge clk);
        chk("rst_abort_ack", 32'(upd_ack), 32'd0);
        step();
        rst = 1'b0; upd_req = 1'b0;

        // Blink pattern on digit 2 over eight frames
        duty = 3'd7; blink_mask = 4'b0100;
        rst = 1'b1; step(); step(); rst = 1'b0;
        for (int f = 0; f < 8; f++) begin
            d2_cnt = 0; d0_cnt = 0;
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                if (seg7_selected == 4'b1011) d2_cnt++;
                if (seg7_selected == 4'b1110) d0_cnt++;
                step();
            end
`ifdef SEG7_BLINK_EN
            chk("blink_d2", 32'(d2_cnt), ((f % 4) < 2) ? 32'd6 : 32'd0);
`else
            chk("noblink_d2", 32'(d2_cnt), 32'd6);
`endif
            chk("blink_d0", 32'(d0_cnt), 32'd6);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in0 = 4'($urandom); in1 = 4'($urandom);
            in2 = 4'($urandom); in3 = 4'($urandom);
            upd_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 20) == 0) duty = 3'($urandom);
            if ($urandom_range(0, 30) == 0) blink_mask = 4'($urandom);
            rst = ($urandom_range(0, 400) == 0);
            step();
        end
        rst = 1'b0; upd_req = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
